// File: rtl/cheri_cst_seq.sv
// cheri_cst_seq: CHERI capability store sequencer.
// Latches a store-capability request and checks it against the authorizing capability
// (tag, SC permission, bounds). It then writes the capability out as twelve 24-bit words
// and finishes with a one-cycle done or fault pulse.
// Optional feature macro: CHERI_CST_TAGCLR_EN. When it is defined, a store that lacks the
// SC permission does not fault. The store goes ahead and writes the tag word as zero.

`ifndef CR_PERM_SC_BIT
`define CR_PERM_SC_BIT 5
`endif

module cheri_cst_seq #(
  parameter int unsigned P_PERM_SC_BIT = `CR_PERM_SC_BIT
) (
  input  logic        iw_clk,
  input  logic        iw_rst,
  input  logic        iw_req_valid,
  output logic        ow_req_ready,
  input  logic [47:0] iw_addr,
  input  logic [47:0] iw_base,
  input  logic [47:0] iw_len,
  input  logic [47:0] iw_cur,
  input  logic [23:0] iw_perms,
  input  logic [23:0] iw_attr,
  input  logic        iw_tag,
  input  logic [47:0] iw_auth_base,
  input  logic [47:0] iw_auth_len,
  input  logic [23:0] iw_auth_perms,
  input  logic        iw_auth_tag,
  output logic        ow_mem_we,
  output logic [47:0] ow_mem_addr,
  output logic [23:0] ow_mem_wdata,
  input  logic        iw_mem_ready,
  output logic        ow_done,
  output logic        ow_fault,
  output logic [1:0]  ow_fault_code
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWrite,
    StDone,
    StFault
  } state_e;

  localparam logic [3:0] LastIdx = 4'd11;

  state_e      state_q;

  // Latched request fields
  logic [47:0] addr_q;
  logic [47:0] base_q;
  logic [47:0] len_q;
  logic [47:0] cur_q;
  logic [23:0] perms_q;
  logic [23:0] attr_q;
  logic        tag_q;
  logic [47:0] auth_base_q;
  logic [47:0] auth_len_q;
  logic [23:0] auth_perms_q;
  logic        auth_tag_q;

  // Write sequencing and registered outputs
  logic [3:0]  idx_q;
  logic        mem_we_q;
  logic [47:0] mem_addr_q;
  logic [23:0] mem_wdata_q;
  logic        done_q;
  logic        fault_q;
  logic [1:0]  fault_code_q;

  // Check results
  logic        perm_ok;
  logic [48:0] store_end;
  logic [48:0] auth_end;
  logic        out_of_bounds;
  logic [1:0]  chk_code;
  logic        tag_word_bit;

  // Word selection for the next write
  logic [3:0]  wr_idx;
  logic [23:0] wr_word;

  // Only the SC bit of the authorizing permissions takes part in the decision
  logic        unused_auth_perms;
  assign unused_auth_perms = ^auth_perms_q;

  assign perm_ok = auth_perms_q[P_PERM_SC_BIT];

  // Sums are 49 bits wide so that a store near the top of the address space cannot wrap
  // past the authorizing bound.
  assign store_end     = {1'b0, addr_q} + 49'd12;
  assign auth_end      = {1'b0, auth_base_q} + {1'b0, auth_len_q};
  assign out_of_bounds = ({1'b0, addr_q} < {1'b0, auth_base_q}) || (store_end > auth_end);

`ifdef CHERI_CST_TAGCLR_EN
  // A missing SC permission downgrades the store to a tag-cleared copy
  assign tag_word_bit = tag_q & perm_ok;
`else
  assign tag_word_bit = tag_q;
`endif

  // Prioritised fault decode: tag, then permission, then bounds
  always_comb begin
    chk_code = 2'd0;
    if (!auth_tag_q) begin
      chk_code = 2'd1;
    end else if (!perm_ok) begin
`ifdef CHERI_CST_TAGCLR_EN
      chk_code = out_of_bounds ? 2'd3 : 2'd0;
`else
      chk_code = 2'd2;
`endif
    end else if (out_of_bounds) begin
      chk_code = 2'd3;
    end
  end

  // Index of the word to present next: 0 when leaving CHECK, else the following word
  always_comb begin
    wr_idx = 4'd0;
    if (state_q == StWrite) begin
      wr_idx = idx_q + 4'd1;
    end
  end

  // Capability serialisation: 24-bit halves, low half first
  always_comb begin
    wr_word = 24'd0;
    unique case (wr_idx)
      4'd0:    wr_word = base_q[23:0];
      4'd1:    wr_word = base_q[47:24];
      4'd2:    wr_word = len_q[23:0];
      4'd3:    wr_word = len_q[47:24];
      4'd4:    wr_word = cur_q[23:0];
      4'd5:    wr_word = cur_q[47:24];
      4'd6:    wr_word = perms_q;
      4'd8:    wr_word = attr_q;
      4'd10:   wr_word = {23'd0, tag_word_bit};
      default: wr_word = 24'd0;
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      base_q       <= '0;
      len_q        <= '0;
      cur_q        <= '0;
      perms_q      <= '0;
      attr_q       <= '0;
      tag_q        <= 1'b0;
      auth_base_q  <= '0;
      auth_len_q   <= '0;
      auth_perms_q <= '0;
      auth_tag_q   <= 1'b0;
      idx_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
    end else begin
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
      unique case (state_q)
        StIdle: begin
          if (iw_req_valid) begin
            addr_q       <= iw_addr;
            base_q       <= iw_base;
            len_q        <= iw_len;
            cur_q        <= iw_cur;
            perms_q      <= iw_perms;
            attr_q       <= iw_attr;
            tag_q        <= iw_tag;
            auth_base_q  <= iw_auth_base;
            auth_len_q   <= iw_auth_len;
            auth_perms_q <= iw_auth_perms;
            auth_tag_q   <= iw_auth_tag;
            state_q      <= StCheck;
          end
        end
        StCheck: begin
          if (chk_code != 2'd0) begin
            state_q      <= StFault;
            done_q       <= 1'b1;
            fault_q      <= 1'b1;
            fault_code_q <= chk_code;
          end else begin
            state_q     <= StWrite;
            idx_q       <= 4'd0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q + {44'd0, wr_idx};
            mem_wdata_q <= wr_word;
          end
        end
        StWrite: begin
          // Address and data hold until the memory takes the word
          if (iw_mem_ready) begin
            if (idx_q == LastIdx) begin
              state_q     <= StDone;
              idx_q       <= 4'd0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
              done_q      <= 1'b1;
            end else begin
              idx_q       <= wr_idx;
              mem_addr_q  <= addr_q + {44'd0, wr_idx};
              mem_wdata_q <= wr_word;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        StFault: begin
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced quiet in the reset cycle itself, so an aborted store cannot
  // leak a write or a completion before the registers clear.
  assign ow_req_ready  = (state_q == StIdle) && !iw_rst;
  assign ow_mem_we     = mem_we_q && !iw_rst;
  assign ow_mem_addr   = iw_rst ? 48'd0 : mem_addr_q;
  assign ow_mem_wdata  = iw_rst ? 24'd0 : mem_wdata_q;
  assign ow_done       = done_q && !iw_rst;
  assign ow_fault      = fault_q && !iw_rst;
  assign ow_fault_code = iw_rst ? 2'd0 : fault_code_q;

endmodule

// File: tb/tb_cheri_cst_seq.sv
// Bench for cheri_cst_seq: table of store vectors plus a reset-abort sequence.
// Expected writes are queued when a request is driven and are checked as writes are accepted.

module tb_cheri_cst_seq;

  localparam int unsigned Sc = 5;
  localparam logic [23:0] ScSet = 24'h000020;
  localparam logic [23:0] ScClr = 24'hFFFFDF;

  localparam logic [47:0] SrcBase = {24'd7, 24'd42};
  localparam logic [47:0] SrcLen  = {24'd9, 24'd88};
  localparam logic [47:0] SrcCur  = {24'd3, 24'd123};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] addr, base, len, cur, auth_base, auth_len;
  logic [23:0] perms, attr, auth_perms;
  logic        tag, auth_tag;
  logic        mem_we;
  logic [47:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ready;
  logic        done, fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  cheri_cst_seq #(.P_PERM_SC_BIT(Sc)) dut (
    .iw_clk        (clk),
    .iw_rst        (rst),
    .iw_req_valid  (req_valid),
    .ow_req_ready  (req_ready),
    .iw_addr       (addr),
    .iw_base       (base),
    .iw_len        (len),
    .iw_cur        (cur),
    .iw_perms      (perms),
    .iw_attr       (attr),
    .iw_tag        (tag),
    .iw_auth_base  (auth_base),
    .iw_auth_len   (auth_len),
    .iw_auth_perms (auth_perms),
    .iw_auth_tag   (auth_tag),
    .ow_mem_we     (mem_we),
    .ow_mem_addr   (mem_addr),
    .ow_mem_wdata  (mem_wdata),
    .iw_mem_ready  (mem_ready),
    .ow_done       (done),
    .ow_fault      (fault),
    .ow_fault_code (fault_code)
  );

  typedef struct {
    logic [47:0] addr;
    logic [47:0] auth_base;
    logic [47:0] auth_len;
    logic [23:0] auth_perms;
    logic        auth_tag;
    logic        toggle;
    logic        exp_fault;
    logic [1:0]  exp_code;
    logic        exp_tag_word;
  } vec_t;

  typedef struct packed {
    logic [47:0] a;
    logic [23:0] d;
  } wr_t;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  wr_t exp_q[$];

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] a, input logic [47:0] ab, input logic [47:0] al,
                              input logic [23:0] ap, input logic at, input logic tg,
                              input logic ef, input logic [1:0] ec, input logic tw);
    vec_t v;
    v.addr = a; v.auth_base = ab; v.auth_len = al; v.auth_perms = ap; v.auth_tag = at;
    v.toggle = tg; v.exp_fault = ef; v.exp_code = ec; v.exp_tag_word = tw;
    return v;
  endfunction

  // Reference image of the stored capability
  function automatic logic [23:0] model_word(input int i, input logic tw);
    case (i)
      0: return 24'd42;
      1: return 24'd7;
      2: return 24'd88;
      3: return 24'd9;
      4: return 24'd123;
      5: return 24'd3;
      6: return 24'hEE;
      8: return 24'hAA;
      10: return {23'd0, tw};
      default: return 24'd0;
    endcase
  endfunction

  // Write monitor: pops the scoreboard on every accepted write, checks stalls hold steady
  logic        hold_v = 1'b0;
  logic [47:0] hold_a;
  logic [23:0] hold_d;
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (hold_v) begin
        chk("hold_addr", {16'd0, mem_addr}, {16'd0, hold_a});
        chk("hold_data", {40'd0, mem_wdata}, {40'd0, hold_d});
      end
      if (mem_ready) begin
        n_acc++;
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
          chk("wr_data", {40'd0, mem_wdata}, {40'd0, e.d});
        end
      end else begin
        hold_v = 1'b1;
        hold_a = mem_addr;
        hold_d = mem_wdata;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic drive_req(input vec_t v);
    addr = v.addr; auth_base = v.auth_base; auth_len = v.auth_len;
    auth_perms = v.auth_perms; auth_tag = v.auth_tag;
    base = SrcBase; len = SrcLen; cur = SrcCur;
    perms = 24'hEE; attr = 24'hAA; tag = 1'b1;
    req_valid = 1'b1;
    mem_ready = 1'b1;
    if (!v.exp_fault) begin
      for (int i = 0; i < 12; i++) begin
        exp_q.push_back({v.addr + 48'(i), model_word(i, v.exp_tag_word)});
      end
    end
  endtask

  // Scrambles inputs after acceptance so an unlatched field shows up as an error
  task automatic scramble();
    req_valid = 1'b0;
    addr = '1; base = '1; len = '1; cur = '1; perms = '1; attr = '1; tag = 1'b0;
    auth_base = '1; auth_len = 48'd0; auth_perms = 24'd0; auth_tag = 1'b0;
  endtask

  // Caller is just past a rising edge; returns at the falling edge of the done cycle
  task automatic run_vec(input int id, input vec_t v);
    int  k;
    bit  seen;
    drive_req(v);
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", id), 64'(req_ready), 64'd1);
    chk($sformatf("v%0d_idle_done", id), 64'(done), 64'd0);
    @(posedge clk); #1;
    scramble();
    k = 1;
    seen = 1'b0;
    while (k <= 200 && !seen) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        k++;
        @(posedge clk); #1;
        if (v.toggle) mem_ready = ~mem_ready;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d_done_timeout: got no done, expected done", id);
      exp_q.delete();
    end else begin
      if (!v.toggle) chk($sformatf("v%0d_latency", id), 64'(k), v.exp_fault ? 64'd2 : 64'd14);
      chk($sformatf("v%0d_fault", id), 64'(fault), 64'(v.exp_fault));
      chk($sformatf("v%0d_code", id), 64'(fault_code), 64'(v.exp_code));
      chk($sformatf("v%0d_we_at_done", id), 64'(mem_we), 64'd0);
      chk($sformatf("v%0d_pending", id), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b1;
    addr = '0; base = '0; len = '0; cur = '0; perms = '0; attr = '0; tag = 1'b0;
    auth_base = '0; auth_len = '0; auth_perms = '0; auth_tag = 1'b0;

    vecs[0] = mk(48'd500, 48'd0, 48'd1000, ScSet, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    vecs[1] = mk(48'd500, 48'd0, 48'd1000, ScSet, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
    vecs[2] = mk(48'd2000, 48'd0, 48'd1000, ScClr, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    vecs[3] = mk(48'd990, 48'd0, 48'd1000, ScSet, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    vecs[4] = mk(48'd988, 48'd0, 48'd1000, ScSet, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
`ifdef CHERI_CST_TAGCLR_EN
    vecs[5] = mk(48'd500, 48'd0, 48'd1000, ScClr, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    vecs[7] = mk(48'd2000, 48'd0, 48'd1000, ScClr, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
`else
    vecs[5] = mk(48'd500, 48'd0, 48'd1000, ScClr, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    vecs[7] = mk(48'd2000, 48'd0, 48'd1000, ScClr, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
`endif
    vecs[6] = mk(48'd50, 48'd100, 48'd1000, ScSet, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
    // Near the top of the address space: a wrapping sum would get these wrong
    vecs[8] = mk(48'hFFFF_FFFF_FFF4, 48'hFFFF_FFFF_FFF0, 48'h20, ScSet, 1'b1, 1'b0,
                 1'b0, 2'd0, 1'b1);
    vecs[9] = mk(48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFF0, 48'h10, ScSet, 1'b1, 1'b0,
                 1'b1, 2'd3, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_code", 64'(fault_code), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Reset in the middle of a store, after five accepted writes
    begin
      int n0;
      int w;
      drive_req(vecs[0]);
      n0 = n_acc;
      @(posedge clk); #1;
      scramble();
      w = 0;
      while (n_acc - n0 < 5 && w < 50) begin
        @(negedge clk); #1;
        w++;
      end
      chk("abort_writes_seen", 64'(n_acc - n0), 64'd5);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("abort_we", 64'(mem_we), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
      end
      rst = 1'b0;
      // A stale write or completion from the aborted store would break this run
      run_vec(10, vecs[0]);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
